// File: rtl/output_writer_if.sv
// output_writer_if: bundles the tile-input, memory-write and status signals of output_writer.
//   slave  modport - the writer's view (tile/lane inputs, mem_wr_ready in; writes and status out)
//   master modport - the driving side (tile/lane source plus memory responder)
// Parameters: POX (16-bit lanes per word), ADDR_W (memory word-address width).
interface output_writer_if #(
  parameter int unsigned POX    = 4,
  parameter int unsigned ADDR_W = 12
);
  logic                  tile_start;
  logic [ADDR_W-1:0]     tile_base;
  logic [POX*16-1:0]     in_data;
  logic                  in_valid;
  logic                  mem_wr_en;
  logic [ADDR_W-1:0]     mem_wr_addr;
  logic [POX*16-1:0]     mem_wr_data;
  logic                  mem_wr_ready;
  logic                  tile_done;
  logic                  busy;
  logic                  err_overflow;
  logic                  err_unexpected;

  modport slave (
    input  tile_start, tile_base, in_data, in_valid, mem_wr_ready,
    output mem_wr_en, mem_wr_addr, mem_wr_data, tile_done, busy, err_overflow, err_unexpected
  );

  modport master (
    output tile_start, tile_base, in_data, in_valid, mem_wr_ready,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, tile_done, busy, err_overflow, err_unexpected
  );
endinterface

// File: rtl/output_writer.sv
// output_writer: collects CHANNEL_N*POY lane words of one tile, tags each with
// base+word index and streams them to memory through a small staging FIFO.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   bus_io - output_writer_if.slave: tile_start/tile_base, in_data/in_valid,
//            mem_wr_en/addr/data with mem_wr_ready, tile_done, busy, sticky error flags
// Optional feature: define OUTPUT_WRITER_RELU_EN to clamp negative signed lanes to zero.
module output_writer #(
  parameter int unsigned CHANNEL_N  = 2,
  parameter int unsigned POX        = 4,
  parameter int unsigned POY        = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  output_writer_if.slave    bus_io
);
  localparam int unsigned Total = CHANNEL_N * POY;
  localparam int unsigned WcW   = $clog2(Total + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DataW = POX * 16;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WcW-1:0]    wcnt_q, wcnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              unx_q, unx_d;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DataW-1:0]  data_mem [FIFO_DEPTH];

  logic              pop, push_req, push, drop;
  logic [ADDR_W-1:0] push_addr;
  logic [DataW-1:0]  proc_data;

  always_comb begin
    proc_data = bus_io.in_data;
`ifdef OUTPUT_WRITER_RELU_EN
    for (int i = 0; i < int'(POX); i++) begin
      if (bus_io.in_data[16*i+15]) proc_data[16*i +: 16] = 16'h0000;
    end
`endif
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop       = (cnt_q != '0) && bus_io.mem_wr_ready;
  assign push_req  = (state_q == StRun) && bus_io.in_valid;
  assign push      = push_req && ((cnt_q < CntW'(FIFO_DEPTH)) || pop);
  assign drop      = push_req && !push;
  assign push_addr = base_q + ADDR_W'(wcnt_q);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | drop;
    unx_d   = unx_q | (bus_io.in_valid && (state_q != StRun));
    cnt_d   = cnt_q + CntW'(push) - CntW'(pop);
    case (state_q)
      StIdle: begin
        if (bus_io.tile_start) begin
          state_d = StRun;
          base_d  = bus_io.tile_base;
          wcnt_d  = '0;
        end
      end
      StRun: begin
        // Dropped words still advance the index so later addresses stay aligned.
        if (bus_io.in_valid) begin
          wcnt_d = wcnt_q + WcW'(1);
          if (wcnt_q == WcW'(Total - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // No pushes in DRAIN, so the last pop empties the FIFO.
        if (pop && (cnt_q == CntW'(1))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unx_q   <= unx_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= push_addr;
      data_mem[wptr_q] <= proc_data;
    end
  end

  assign bus_io.mem_wr_en      = (cnt_q != '0);
  assign bus_io.mem_wr_addr    = (cnt_q != '0) ? addr_mem[rptr_q] : '0;
  assign bus_io.mem_wr_data    = (cnt_q != '0) ? data_mem[rptr_q] : '0;
  assign bus_io.tile_done      = done_q;
  assign bus_io.busy           = (state_q != StIdle);
  assign bus_io.err_overflow   = ovf_q;
  assign bus_io.err_unexpected = unx_q;
endmodule

// File: tb/tb_output_writer.sv
module tb_output_writer;
  localparam int Total = 8;
  localparam int Depth = 4;

  typedef struct packed {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];

  output_writer_if #(.POX(4), .ADDR_W(12)) bus ();

  output_writer #(
    .CHANNEL_N (2),
    .POX       (4),
    .POY       (4),
    .FIFO_DEPTH(4),
    .ADDR_W    (12)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  // Record every transfer and tile_done pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_wr_en && bus.mem_wr_ready) obs_q.push_back('{bus.mem_wr_addr, bus.mem_wr_data});
      if (bus.tile_done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_lane(input logic [63:0] d);
    logic [63:0] r;
    r = d;
`ifdef OUTPUT_WRITER_RELU_EN
    for (int i = 0; i < 4; i++) if ($signed(d[16*i +: 16]) < 0) r[16*i +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  task automatic apply_reset();
    bus.tile_start = 1'b0; bus.tile_base = '0; bus.in_data = '0;
    bus.in_valid = 1'b0; bus.mem_wr_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives one tile and builds exp_q from a queue model of the staging FIFO:
  // accept if fewer than Depth held or the head leaves this cycle, else drop
  // (index still advances); the head leaves whenever something is held and ready is high.
  task automatic run_tile(input logic [11:0] base, input logic [63:0] vpat,
                          input logic [63:0] rpat, input bit fixed, input logic [63:0] fdata);
    wr_t fifo[$];
    int  wcnt = 0;
    int  cyc  = 0;
    bit  v, r, xfer, acc;
    exp_q.delete(); obs_q.delete(); done_cnt = 0;
    bus.tile_start = 1'b1; bus.tile_base = base; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.tile_start = 1'b0;
    while ((wcnt < Total || fifo.size() != 0) && cyc < 500) begin
      v = (cyc < 64) ? vpat[cyc] : 1'b1;
      if (wcnt >= Total) v = 1'b0;
      r = (cyc < 64) ? rpat[cyc] : 1'b1;
      bus.in_valid = v; bus.mem_wr_ready = r;
      bus.in_data = fixed ? fdata : {$urandom, $urandom};
      xfer = (fifo.size() != 0) && r;
      acc  = (fifo.size() < Depth) || xfer;
      if (xfer) exp_q.push_back(fifo.pop_front());
      if (v) begin
        if (acc) fifo.push_back('{base + 12'(wcnt), ref_lane(bus.in_data)});
        wcnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.mem_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.tile_start = 1'b0; bus.tile_base = '0; bus.in_data = '0;
    bus.in_valid = 1'b0; bus.mem_wr_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    total++;
    if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.tile_done, bus.busy,
         bus.err_overflow, bus.err_unexpected} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b addr=%h data=%h done=%b busy=%b ovf=%b unx=%b want all 0",
               bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.tile_done, bus.busy,
               bus.err_overflow, bus.err_unexpected);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    run_tile(12'h100, '1, '1, 1'b0, '0);
    total++;
    if (obs_q.size() != 8) begin
      bad++; $display("FAIL basic_count got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== 12'h100 + 12'(i) || obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_word%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
    total++;
    if (done_cnt != 1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL basic_done got pulses=%0d busy=%b want 1/0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    run_tile(12'h100, '1, ~64'hF, 1'b0, '0);
    total++;
    if (obs_q.size() != 8 || bus.err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL fullpp_count got %0d ovf=%b want 8/0", obs_q.size(), bus.err_overflow);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== 12'h100 + 12'(i) || obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL fullpp_word%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    run_tile(12'hFFE, '1, '1, 1'b0, '0);
    total++;
    if (obs_q.size() != 8) begin
      bad++; $display("FAIL wrap_count got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== 12'hFFE + 12'(i) || obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL wrap_word%0d got %h want %h", i, obs_q[i].addr, exp_q[i].addr);
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] want [6];
    want = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h106, 12'h107};
    apply_reset();
    run_tile(12'h100, '1, ~64'h3F, 1'b0, '0);
    total++;
    if (obs_q.size() != 6 || bus.err_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_count got %0d ovf=%b want 6/1", obs_q.size(), bus.err_overflow);
    end
    for (int i = 0; i < obs_q.size() && i < 6 && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== want[i] || obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL ovf_word%0d got %h/%h want %h/%h", i, obs_q[i].addr, obs_q[i].data,
                 want[i], exp_q[i].data);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL ovf_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [11:0] base;
      base = 12'($urandom);
      run_tile(base, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, '0);
      total++;
      if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
        bad++;
        $display("FAIL rand%0d_count got %0d done=%0d want %0d/1", t, obs_q.size(), done_cnt,
                 exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand%0d_word%0d got %h/%h want %h/%h", t, i, obs_q[i].addr,
                   obs_q[i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
  endtask

  task automatic test_relu();
    logic [63:0] din, want;
    din = 64'h7FFF_0000_FFFF_8000;
`ifdef OUTPUT_WRITER_RELU_EN
    want = 64'h7FFF_0000_0000_0000;
`else
    want = 64'h7FFF_0000_FFFF_8000;
`endif
    apply_reset();
    run_tile(12'h040, '1, '1, 1'b1, din);
    total++;
    if (obs_q.size() != 8) begin
      bad++; $display("FAIL relu_count got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== want) begin
        bad++; $display("FAIL relu_word%0d got %h want %h", i, obs_q[i].data, want);
      end
    end
  endtask

  task automatic test_reset_midtile();
    apply_reset();
    obs_q.delete();
    bus.tile_start = 1'b1; bus.tile_base = 12'h100;
    @(posedge clk); #1;
    bus.tile_start = 1'b0; bus.mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.mem_wr_en !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL midrst_pending got en=%b busy=%b want 1/1", bus.mem_wr_en, bus.busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.mem_wr_en, bus.busy, bus.mem_wr_addr, bus.mem_wr_data} !== '0) begin
      bad++;
      $display("FAIL midrst_clear got en=%b busy=%b addr=%h data=%h want 0", bus.mem_wr_en,
               bus.busy, bus.mem_wr_addr, bus.mem_wr_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.mem_wr_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.err_unexpected !== 1'b0 || bus.mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle got unx=%b en=%b want 0/0", bus.err_unexpected, bus.mem_wr_en);
    end
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.err_unexpected !== 1'b1 || bus.busy !== 1'b0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_unexpected got unx=%b busy=%b writes=%0d want 1/0/0",
               bus.err_unexpected, bus.busy, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_push_pop();
    test_wrap();
    test_overflow();
    test_random();
    test_relu();
    test_reset_midtile();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
